// File: rtl/sample_packer_pkg.sv
// Shared types and constants for the sample packer: word/sample widths,
// FSM state and word-index enums, the stored pair layout, and the word
// selector used to slice a stored pair into output words.
package sample_packer_pkg;

    localparam int WORD_W   = 16;
    localparam int SAMPLE_W = 32;
    localparam int PAIR_W   = 2 * SAMPLE_W;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef enum logic [1:0] {
        LOW_HI,
        LOW_LO,
        HIGH_HI,
        HIGH_LO
    } word_idx_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] low_pass;
        logic [SAMPLE_W-1:0] high_pass;
    } pair_t;

    // Pick one 16-bit word out of a stored pair; bits pass through untouched.
    function automatic logic [WORD_W-1:0] select_word(input pair_t p, input word_idx_t idx);
        logic [WORD_W-1:0] w;
        case (idx)
            LOW_HI:  w = p.low_pass[SAMPLE_W-1:WORD_W];
            LOW_LO:  w = p.low_pass[WORD_W-1:0];
            HIGH_HI: w = p.high_pass[SAMPLE_W-1:WORD_W];
            default: w = p.high_pass[WORD_W-1:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sample_packer_if.sv
// Sample-pair input and word-stream output of the packer in one bundle.
// master: the filter/consumer side (drives samples and out_ready).
// slave: the packer side (drives the word stream).
interface sample_packer_if;
    import sample_packer_pkg::*;

    logic                sample_valid;
    logic [SAMPLE_W-1:0] low_pass;
    logic [SAMPLE_W-1:0] high_pass;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_data;
    logic [1:0]          out_index;
    logic                out_last;

    modport master (
        output sample_valid, low_pass, high_pass, out_ready,
        input  out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  sample_valid, low_pass, high_pass, out_ready,
        output out_valid, out_data, out_index, out_last
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data (head visible combinationally).
// Latency: a push at edge N is visible on rdata/count right after edge N.
// Backpressure: push ignored when full unless a pop happens the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_packer.sv
// Buffers 64-bit low/high sample pairs and emits each as four 16-bit words.
// Latency: pair written into an empty FIFO at edge N shows word 0 after N+1.
// Backpressure: words hold under out_ready=0; pairs arriving while full drop.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    sample_packer_if.slave     bus,
    output logic [LW-1:0]      level,
    output logic               overflow,
    output logic [7:0]         drop_count
);

    state_t     state;
    state_t     state_nxt;
    word_idx_t  idx;
    pair_t      wr_pair;
    pair_t      head;
    logic [PAIR_W-1:0] head_raw;
    logic       fifo_full;
    logic       fifo_empty;
    logic       xfer;
    logic       pop;
    logic       push;
    logic       drop;

    // The filter cannot be stalled, so a pair is either stored or counted as dropped.
    assign wr_pair = '{low_pass: bus.low_pass, high_pass: bus.high_pass};
    assign xfer    = bus.out_valid && bus.out_ready;
    assign pop     = xfer && (idx == HIGH_LO);
    assign push    = bus.sample_valid && !rst && (!fifo_full || pop);
    assign drop    = bus.sample_valid && !rst && fifo_full && !pop;
    assign head    = pair_t'(head_raw);

    sync_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_pair),
        .pop   (pop),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (level)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave SEND only when the last stored pair finishes and nothing replaces it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (pop && (level == LW'(1)) && !push) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: word data is zeroed whenever nothing valid is presented.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.out_index = idx;
        if (state == SEND) begin
            bus.out_valid = 1'b1;
            bus.out_data  = select_word(head, idx);
            bus.out_last  = (idx == HIGH_LO);
        end
    end

    // Word index advances only on an accepted word, wrapping 3 -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= LOW_HI;
        end else if (xfer) begin
            idx <= word_idx_t'(idx + 2'd1);
        end
    end

    // Sticky overflow flag and saturating count of discarded pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule
